// File: rtl/code_lock_pkg.sv
// Shared definitions for the front-panel combination lock: state codes,
// LED colour constants and small helpers used by the lock and its bench.
package code_lock_pkg;

  // Lock states, kept as plain constants so the encoding stays fixed.
  localparam logic [1:0] ST_LOCKED  = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  // One RGB LED, packed as {r,g,b}.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t RED = 3'b100;
  localparam rgb_t GRN = 3'b010;
  localparam rgb_t MAG = 3'b101;

  // Slot index width; a single-slot lock still carries a 1-bit index.
  function automatic int slot_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Slot LED colour cycles through the seven non-black colours.
  function automatic rgb_t slot_colour(input int unsigned s);
    return rgb_t'(3'((s % 7) + 1));
  endfunction

  // Status LED colour; the lockout red blinks with the supplied phase bit.
  function automatic rgb_t status_colour(input logic [1:0] st, input logic blink);
    rgb_t c;
    c = RED;
    case (st)
      ST_OPEN:    c = GRN;
      ST_FAIL:    c = MAG;
      ST_LOCKOUT: c = RED ^ {blink, 2'b00};
      default:    c = RED;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/code_lock_if.sv
// Panel-side bundle of the lock: code switches, raw buttons and the LED/slot
// outputs. The panel (or a bench) is the master, the lock is the slave.
interface code_lock_if #(
  parameter int KEY_W  = 8,
  parameter int SLOT_W = 1
);

  logic [KEY_W-1:0]  key;
  logic              btn_sel;
  logic              btn_chk;
  logic              btn_set;
  logic [SLOT_W-1:0] slot;
  logic              r_led1;
  logic              g_led1;
  logic              b_led1;
  logic              r_led2;
  logic              g_led2;
  logic              b_led2;
  logic              prog_done;

  modport master (
    output key, btn_sel, btn_chk, btn_set,
    input  slot, r_led1, g_led1, b_led1, r_led2, g_led2, b_led2, prog_done
  );

  modport slave (
    input  key, btn_sel, btn_chk, btn_set,
    output slot, r_led1, g_led1, b_led1, r_led2, g_led2, b_led2, prog_done
  );

endinterface

// File: rtl/code_lock_debounce.sv
// Push-button debouncer: the button must stay high for DEB_CYCLES samples
// before a single one-cycle press pulse is produced; releasing re-arms it.
module btn_debounce #(
  parameter int DEB_CYCLES = 1048575
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count held-high samples, saturating so a long hold fires only once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= btn_in && (cnt == CNT_FIRE);
      if (!btn_in) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/code_lock.sv
// Multi-slot combination lock. Debounced buttons select a slot, check the
// switch code against the stored code, or reprogram the open slot. Repeated
// mismatches lead to a timed lockout. Slot and LED outputs are registered.
module code_lock
  import code_lock_pkg::*;
#(
  parameter int               KEY_W          = 8,
  parameter int               NUM_SLOTS      = 2,
  parameter logic [KEY_W-1:0] DEFAULT_CODE   = 8'hF0,
  parameter int               MAX_TRIES      = 3,
  parameter int               DEB_CYCLES     = 1048575,
  parameter int               FLASH_CYCLES   = 12500000,
  parameter int               LOCKOUT_CYCLES = 250000000
) (
  input logic       clk,
  input logic       rst_n,
  code_lock_if.slave bus
);

  localparam int SLOT_W    = slot_width(NUM_SLOTS);
  localparam int FAIL_W    = $clog2(MAX_TRIES + 1);
  localparam int TIMER_MAX = (FLASH_CYCLES > LOCKOUT_CYCLES) ? FLASH_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int PHASE_W   = $clog2(FLASH_CYCLES + 1);

  localparam logic [SLOT_W-1:0]  LAST_SLOT   = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [FAIL_W-1:0]  TRIES_LIMIT = FAIL_W'(MAX_TRIES);
  localparam logic [TIMER_W-1:0] FLASH_LAST  = TIMER_W'(FLASH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(FLASH_CYCLES - 1);

  logic [1:0]         state;
  logic [SLOT_W-1:0]  slot_q;
  logic [FAIL_W-1:0]  fail_cnt;
  logic [FAIL_W-1:0]  fail_next;
  logic [TIMER_W-1:0] timer;
  logic [PHASE_W-1:0] phase;
  logic               blink;
  logic [KEY_W-1:0]   codes [NUM_SLOTS];

  logic press_chk;
  logic press_set;
  logic press_sel;
  logic ev_chk;
  logic ev_set;
  logic ev_sel;
  logic key_match;
  logic code_we;
  logic enter_lockout;

  logic [SLOT_W-1:0] slot_out;
  rgb_t              led1_q;
  rgb_t              led2_q;
  logic              prog_done_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (bus.btn_chk),
    .press  (press_chk)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (bus.btn_set),
    .press  (press_set)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (bus.btn_sel),
    .press  (press_sel)
  );

  // Resolve simultaneous presses (check wins, then set, then select) and
  // decode the events that touch the code store and the blink generator.
  always_comb begin
    ev_chk        = press_chk;
    ev_set        = press_set && !press_chk;
    ev_sel        = press_sel && !press_chk && !press_set;
    key_match     = (bus.key == codes[slot_q]);
    fail_next     = fail_cnt + FAIL_W'(1);
    code_we       = (state == ST_OPEN) && ev_set;
    enter_lockout = (state == ST_LOCKED) && ev_chk && !key_match &&
                    (fail_next == TRIES_LIMIT);
  end

  // Main lock FSM with the shared FAIL/LOCKOUT timer, cleared on each entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_LOCKED;
      slot_q   <= '0;
      fail_cnt <= '0;
      timer    <= '0;
    end else begin
      case (state)
        ST_LOCKED: begin
          if (ev_chk) begin
            timer <= '0;
            if (key_match) begin
              state    <= ST_OPEN;
              fail_cnt <= '0;
            end else begin
              fail_cnt <= fail_next;
              state    <= (fail_next == TRIES_LIMIT) ? ST_LOCKOUT : ST_FAIL;
            end
          end else if (ev_sel) begin
            slot_q <= (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
          end
        end
        ST_OPEN: begin
          if (ev_chk) begin
            state <= ST_LOCKED;
            timer <= '0;
          end
        end
        ST_FAIL: begin
          if (timer == FLASH_LAST) begin
            state <= ST_LOCKED;
            timer <= '0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        ST_LOCKOUT: begin
          if (timer == LOCK_LAST) begin
            state    <= ST_LOCKED;
            timer    <= '0;
            fail_cnt <= '0;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: begin
          state <= ST_LOCKED;
          timer <= '0;
        end
      endcase
    end
  end

  // Lockout blink phase: red toggles every FLASH_CYCLES, starting lit.
  always_ff @(posedge clk) begin
    if (!rst_n || enter_lockout) begin
      phase <= '0;
      blink <= 1'b0;
    end else if (state == ST_LOCKOUT) begin
      if (phase == PHASE_LAST) begin
        phase <= '0;
        blink <= ~blink;
      end else begin
        phase <= phase + PHASE_W'(1);
      end
    end
  end

  // Code store: defaults on reset (even slots plain, odd slots inverted),
  // overwritten by a set press while open, which also pulses prog_done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        codes[i] <= (i % 2 == 0) ? DEFAULT_CODE : ~DEFAULT_CODE;
      end
      prog_done_q <= 1'b0;
    end else begin
      prog_done_q <= code_we;
      if (code_we) begin
        codes[slot_q] <= bus.key;
      end
    end
  end

  // Registered panel outputs, one cycle behind the state they show.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_out <= '0;
      led1_q   <= slot_colour(32'd0);
      led2_q   <= RED;
    end else begin
      slot_out <= slot_q;
      led1_q   <= slot_colour(32'(slot_q));
      led2_q   <= status_colour(state, blink);
    end
  end

  assign bus.slot      = slot_out;
  assign bus.r_led1    = led1_q.r;
  assign bus.g_led1    = led1_q.g;
  assign bus.b_led1    = led1_q.b;
  assign bus.r_led2    = led2_q.r;
  assign bus.g_led2    = led2_q.g;
  assign bus.b_led2    = led2_q.b;
  assign bus.prog_done = prog_done_q;

endmodule

// File: tb/tb_code_lock.sv
// Bench for code_lock: a two-slot and a three-slot lock share the same panel
// inputs. A press-level reference model predicts every output each cycle;
// directed steps add fixed expectations at the interesting points.
module tb_code_lock;
  import code_lock_pkg::*;

  localparam int         DEB   = 4;
  localparam int         FLASH = 8;
  localparam int         LOCK  = 32;
  localparam int         TRIES = 3;
  localparam logic [7:0] DEF   = 8'hF0;
  localparam int         NS_A  = 2;
  localparam int         NS_B  = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key   = 8'h00;
  logic       b_chk = 1'b0;
  logic       b_set = 1'b0;
  logic       b_sel = 1'b0;

  code_lock_if #(.KEY_W(8), .SLOT_W(slot_width(NS_A))) bus_a ();
  code_lock_if #(.KEY_W(8), .SLOT_W(slot_width(NS_B))) bus_b ();

  assign bus_a.key     = key;
  assign bus_a.btn_chk = b_chk;
  assign bus_a.btn_set = b_set;
  assign bus_a.btn_sel = b_sel;
  assign bus_b.key     = key;
  assign bus_b.btn_chk = b_chk;
  assign bus_b.btn_set = b_set;
  assign bus_b.btn_sel = b_sel;

  code_lock #(
    .KEY_W(8), .NUM_SLOTS(NS_A), .DEFAULT_CODE(DEF), .MAX_TRIES(TRIES),
    .DEB_CYCLES(DEB), .FLASH_CYCLES(FLASH), .LOCKOUT_CYCLES(LOCK)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  code_lock #(
    .KEY_W(8), .NUM_SLOTS(NS_B), .DEFAULT_CODE(DEF), .MAX_TRIES(TRIES),
    .DEB_CYCLES(DEB), .FLASH_CYCLES(FLASH), .LOCKOUT_CYCLES(LOCK)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  typedef enum int {M_LOCKED, M_OPEN, M_FAIL, M_LOCKOUT} mstate_e;

  mstate_e    m_state [2];
  int         m_slot  [2];
  int         m_fails [2];
  int         m_left  [2];
  int         m_since [2];
  logic [7:0] m_code  [2][3];
  int         num_slots [2];
  int         e_slot [2];
  int         e_led1 [2];
  int         e_led2 [2];
  int         e_pd   [2];
  int         hold   [3];
  bit         pend   [3];

  int checks   = 0;
  int failures = 0;

  function automatic int lamp(input mstate_e s, input int since);
    case (s)
      M_OPEN:    return 2;
      M_FAIL:    return 5;
      M_LOCKOUT: return ((since / FLASH) % 2 == 1) ? 0 : 4;
      default:   return 4;
    endcase
  endfunction

  task automatic model_edge();
    bit btn [3];
    bit chk, set, sel;
    btn[0] = b_chk;
    btn[1] = b_set;
    btn[2] = b_sel;
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_state[m] = M_LOCKED;
        m_slot[m]  = 0;
        m_fails[m] = 0;
        m_left[m]  = 0;
        m_since[m] = 0;
        for (int s = 0; s < 3; s++) m_code[m][s] = (s % 2 == 0) ? DEF : ~DEF;
        e_slot[m] = 0;
        e_led1[m] = 1;
        e_led2[m] = 4;
        e_pd[m]   = 0;
      end
      for (int b = 0; b < 3; b++) begin
        hold[b] = 0;
        pend[b] = 1'b0;
      end
    end else begin
      chk = pend[0];
      set = pend[1] && !pend[0];
      sel = pend[2] && !pend[0] && !pend[1];
      for (int m = 0; m < 2; m++) begin
        e_slot[m] = m_slot[m];
        e_led1[m] = (m_slot[m] % 7) + 1;
        e_led2[m] = lamp(m_state[m], m_since[m]);
        e_pd[m]   = 0;
        case (m_state[m])
          M_LOCKED: begin
            if (chk) begin
              if (key == m_code[m][m_slot[m]]) begin
                m_state[m] = M_OPEN;
                m_fails[m] = 0;
              end else begin
                m_fails[m]++;
                if (m_fails[m] == TRIES) begin
                  m_state[m] = M_LOCKOUT;
                  m_left[m]  = LOCK;
                  m_since[m] = 0;
                end else begin
                  m_state[m] = M_FAIL;
                  m_left[m]  = FLASH;
                end
              end
            end else if (sel) begin
              m_slot[m] = (m_slot[m] + 1) % num_slots[m];
            end
          end
          M_OPEN: begin
            if (chk) begin
              m_state[m] = M_LOCKED;
            end else if (set) begin
              m_code[m][m_slot[m]] = key;
              e_pd[m] = 1;
            end
          end
          M_FAIL: begin
            m_left[m]--;
            if (m_left[m] == 0) m_state[m] = M_LOCKED;
          end
          default: begin
            m_left[m]--;
            m_since[m]++;
            if (m_left[m] == 0) begin
              m_state[m] = M_LOCKED;
              m_fails[m] = 0;
            end
          end
        endcase
      end
      for (int b = 0; b < 3; b++) begin
        hold[b] = btn[b] ? hold[b] + 1 : 0;
        pend[b] = (hold[b] == DEB);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a_slot", bus_a.slot, e_slot[0]);
    check("a_led1", {bus_a.r_led1, bus_a.g_led1, bus_a.b_led1}, e_led1[0]);
    check("a_led2", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, e_led2[0]);
    check("a_prog_done", bus_a.prog_done, e_pd[0]);
    check("b_slot", bus_b.slot, e_slot[1]);
    check("b_led1", {bus_b.r_led1, bus_b.g_led1, bus_b.b_led1}, e_led1[1]);
    check("b_led2", {bus_b.r_led2, bus_b.g_led2, bus_b.b_led2}, e_led2[1]);
    check("b_prog_done", bus_b.prog_done, e_pd[1]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic set_btns(input bit c, input bit s, input bit l);
    b_chk = c;
    b_set = s;
    b_sel = l;
  endtask

  task automatic press(input bit c, input bit s, input bit l, input int cycles);
    set_btns(c, s, l);
    ticks(cycles);
    set_btns(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    ticks(n);
    rst_n = 1'b1;
  endtask

  initial begin
    num_slots[0] = NS_A;
    num_slots[1] = NS_B;

    // Reset values
    do_reset(2);
    check("rst_led2", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b100);
    check("rst_led1", {bus_a.r_led1, bus_a.g_led1, bus_a.b_led1}, 3'b001);
    check("rst_slot", bus_a.slot, 0);
    check("rst_prog_done", bus_a.prog_done, 0);

    // Correct default code opens slot 0
    key = 8'hF0;
    press(1, 0, 0, DEB); ticks(2);
    check("t1_led2_a", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b010);
    check("t1_led2_b", {bus_b.r_led2, bus_b.g_led2, bus_b.b_led2}, 3'b010);
    check("t1_slot", bus_a.slot, 0);
    check("t1_led1", {bus_a.r_led1, bus_a.g_led1, bus_a.b_led1}, 3'b001);

    // Relock, select slot 1, open with inverted default, relock
    press(1, 0, 0, DEB); ticks(2);
    press(0, 0, 1, DEB); ticks(2);
    key = 8'h0F;
    press(1, 0, 0, DEB); ticks(2);
    check("t2_slot", bus_a.slot, 1);
    check("t2_led1", {bus_a.r_led1, bus_a.g_led1, bus_a.b_led1}, 3'b010);
    check("t2_open", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b010);
    press(1, 0, 0, DEB); ticks(2);
    check("t2_relock", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b100);

    // Three wrong entries: FAIL twice, then LOCKOUT ignoring buttons
    press(0, 0, 1, DEB); ticks(2);
    check("t3_slot_a", bus_a.slot, 0);
    check("t3_slot_b", bus_b.slot, 2);
    key = 8'h00;
    press(1, 0, 0, DEB); ticks(2);
    check("t3_fail1", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b101);
    ticks(10);
    press(1, 0, 0, DEB); ticks(2);
    check("t3_fail2", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b101);
    ticks(10);
    press(1, 0, 0, DEB); ticks(2);
    check("t3_lockout", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b100);
    ticks(8);
    check("t3_blink", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b000);
    press(1, 0, 0, DEB); ticks(2);
    ticks(20);
    check("t3_unlocked", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b100);
    press(1, 0, 0, DEB); ticks(2);
    check("t3_count_cleared", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b101);
    ticks(10);

    // Reprogram the open slot and use the new code
    key = 8'hF0;
    press(1, 0, 0, DEB); ticks(2);
    check("t4_open", {bus_b.r_led2, bus_b.g_led2, bus_b.b_led2}, 3'b010);
    key = 8'hA5;
    press(0, 1, 0, DEB); ticks(1);
    check("t4_prog_pulse", bus_a.prog_done, 1);
    ticks(1);
    check("t4_prog_end", bus_a.prog_done, 0);
    press(1, 0, 0, DEB); ticks(2);
    key = 8'hF0;
    press(1, 0, 0, DEB); ticks(2);
    check("t4_old_code", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b101);
    ticks(10);
    key = 8'hA5;
    press(1, 0, 0, DEB); ticks(2);
    check("t4_new_code", {bus_b.r_led2, bus_b.g_led2, bus_b.b_led2}, 3'b010);

    // Bouncing button, long hold, same-cycle chk+sel
    press(1, 0, 0, DEB); ticks(2);
    for (int i = 0; i < 5; i++) begin
      press(1, 0, 0, 3);
      ticks(1);
    end
    ticks(2);
    check("t5_bounce", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b100);
    press(1, 0, 0, 10); ticks(2);
    check("t5_long_hold", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b010);
    press(1, 0, 0, DEB); ticks(2);
    key = 8'h00;
    press(1, 0, 1, DEB); ticks(2);
    check("t5_prio_led2", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b101);
    check("t5_prio_slot", bus_b.slot, 2);
    ticks(10);

    // Three-slot wrap, then reset in the middle of LOCKOUT
    do_reset(1);
    check("t6_rst_slot", bus_b.slot, 0);
    press(0, 0, 1, DEB); ticks(2);
    check("t6_sel1", bus_b.slot, 1);
    press(0, 0, 1, DEB); ticks(2);
    check("t6_sel2", bus_b.slot, 2);
    press(0, 0, 1, DEB); ticks(2);
    check("t6_sel_wrap", bus_b.slot, 0);
    key = 8'h00;
    for (int i = 0; i < 2; i++) begin
      press(1, 0, 0, DEB); ticks(10);
    end
    press(1, 0, 0, DEB); ticks(2);
    ticks(10);
    check("t6_mid_lockout", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b000);
    do_reset(1);
    check("t6_abort_led2", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b100);
    check("t6_abort_slot", bus_a.slot, 0);
    key = 8'hF0;
    press(1, 0, 0, DEB); ticks(2);
    check("t6_defaults_a", {bus_a.r_led2, bus_a.g_led2, bus_a.b_led2}, 3'b010);
    check("t6_defaults_b", {bus_b.r_led2, bus_b.g_led2, bus_b.b_led2}, 3'b010);

    // Random panel activity against the reference model
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 3))
        0:       key = 8'hF0;
        1:       key = 8'h0F;
        2:       key = 8'hA5;
        default: key = 8'($urandom);
      endcase
      if ($urandom_range(0, 99) < 3) begin
        do_reset(1);
      end else begin
        press($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(1, 7));
        ticks($urandom_range(1, 12));
      end
    end
    ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
